// File: rtl/srl_chain_checker.sv
`default_nettype none
// ============================================================================
// srl_chain_checker : PRBS stimulus + compare engine for SRL16 delay chains.
// Optional: define SRL_CHECK_ERR_COUNT_EN to build the err_count counter. Rev 1.0
// ============================================================================
module srl_chain_checker #(
   parameter int          NUM_LANES = 8,
   parameter int          DELAY     = 64,
   parameter logic [15:0] SEED      = 16'hACE1,
   parameter int          INIT_WAIT = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   output logic [NUM_LANES-1:0] srl_d,
   output logic                 srl_ce,
   input  logic [NUM_LANES-1:0] srl_q,
   output logic [NUM_LANES-1:0] error,
   output logic                 checking,
   output logic [15:0]          err_count
);

   localparam int                FILL_W    = $clog2(DELAY + 1);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DELAY - 1);
   localparam int                WAIT_W    = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((INIT_WAIT > 0) ? INIT_WAIT - 1 : 0);

   typedef enum logic [1:0] {
      ST_WAIT  = 2'd0,
      ST_FILL  = 2'd1,
      ST_CHECK = 2'd2
   } state_t;

   generate
      if (SEED == 16'h0000) begin : g_bad_seed
         $error("srl_chain_checker: SEED must be non-zero");
      end
   endgenerate

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   // Async assert, sync deassert; everything below is reset by rst_int_n.
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   state_t                state_q, state_d;
   logic [WAIT_W-1:0]     wait_cnt_q, wait_cnt_d;
   logic [FILL_W-1:0]     fill_cnt_q, fill_cnt_d;
   logic [15:0]           gen_lfsr_q, ref_lfsr_q;
   logic [NUM_LANES-1:0]  srl_d_q, error_q, error_d, mism;
   logic                  gen_adv;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      fill_cnt_d = fill_cnt_q;
      case (state_q)
         ST_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) state_d    = ST_FILL;
            else                         wait_cnt_d = wait_cnt_q + WAIT_W'(1);
         end
         ST_FILL: begin
            if (fill_cnt_q == FILL_LAST) state_d    = ST_CHECK;
            else                         fill_cnt_d = fill_cnt_q + FILL_W'(1);
         end
         ST_CHECK: state_d = ST_CHECK;
         default:  state_d = ST_WAIT;
      endcase
   end

   assign srl_ce   = (state_q != ST_WAIT);
   assign checking = (state_q == ST_CHECK);
   // srl_d is loaded one edge ahead of srl_ce so it is valid for every enabled shift,
   // which lines srl_q up with ref_lfsr on the first CHECK cycle.
   assign gen_adv  = (state_d != ST_WAIT);
   assign mism     = srl_q ^ ref_lfsr_q[NUM_LANES-1:0];
   assign error_d  = checking ? (error_q | mism) : error_q;

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q    <= ST_WAIT;
         wait_cnt_q <= '0;
         fill_cnt_q <= '0;
         gen_lfsr_q <= SEED;
         ref_lfsr_q <= SEED;
         srl_d_q    <= '0;
         error_q    <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         fill_cnt_q <= fill_cnt_d;
         error_q    <= error_d;
         if (gen_adv) begin
            srl_d_q    <= gen_lfsr_q[NUM_LANES-1:0];
            gen_lfsr_q <= lfsr_next(gen_lfsr_q);
         end
         if (checking) ref_lfsr_q <= lfsr_next(ref_lfsr_q);
      end
   end

   assign srl_d = srl_d_q;
   assign error = error_q;

`ifdef SRL_CHECK_ERR_COUNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n)
         err_cnt_q <= 16'h0000;
      else if (checking && (|mism) && (err_cnt_q != 16'hFFFF))
         err_cnt_q <= err_cnt_q + 16'd1;
   end
   assign err_count = err_cnt_q;
`else
   assign err_count = 16'h0000;
`endif

endmodule
`default_nettype wire
